aes_block_stream: RTL and testbench

//  Stream front/back end for the combinational AES cipher core. Packs 32-bit input beats into
//  4x4 byte key/data matrices, drives them to cipher_0 and captures its o matrix after a

---
 rtl/aes_stream_pkg.sv | 24 ++
 rtl/aes_word_packer.sv | 21 ++
 rtl/aes_block_stream.sv | 121 ++++++++++++
 tb/tb_aes_block_stream.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES block stream front/back end.
package aes_stream_pkg;
  localparam int BLOCK_WORDS = 4;
  localparam int WORD_W      = 32;

  // One matrix column: [row] of bytes. A matrix is [column][row][bit].
  typedef logic [3:0][7:0]                  byte_col_t;
  typedef logic [BLOCK_WORDS-1:0][3:0][7:0] byte_mat_t;

  typedef enum logic [2:0] {IDLE, LD_KEY, LD_DATA, CAPT, SEND} state_t;

  // Byte 0 of a bus word sits in bits 31:24 and lands in row 0.
  function automatic byte_col_t word_to_col(input logic [WORD_W-1:0] w);
    byte_col_t c;
    for (int b = 0; b < 4; b++) c[b] = w[WORD_W-1-8*b -: 8];
    return c;
  endfunction

  function automatic logic [WORD_W-1:0] col_to_word(input byte_col_t c);
    logic [WORD_W-1:0] w;
    for (int b = 0; b < 4; b++) w[WORD_W-1-8*b -: 8] = c[b];
    return w;
  endfunction
endpackage

// File: rtl/aes_word_packer.sv
// Writes one 32-bit word into a selected column of a 4x4 byte matrix.
module aes_word_packer
  import aes_stream_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [1:0]        idx_i,
  input  logic [WORD_W-1:0] word_i,
  output byte_mat_t         mat_o
);
  byte_mat_t mat_q;

  // Overwrite the addressed column; untouched columns keep their bytes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   mat_q <= '0;
    else if (we_i) mat_q[idx_i] <= word_to_col(word_i);
  end

  assign mat_o = mat_q;
endmodule

// File: rtl/aes_block_stream.sv
// Word-stream wrapper around the combinational AES cipher: packs key/plaintext
// beats into matrices, waits out the cipher latency, and streams ciphertext back.
module aes_block_stream
  import aes_stream_pkg::*;
#(
  parameter int CIPHER_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_key,
  output byte_mat_t         key_o,
  output byte_mat_t         data_o,
  input  byte_mat_t         cipher_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              key_valid,
  output logic              err
);
  localparam int                WAIT_W    = (CIPHER_LAT < 1) ? 1 : $clog2(CIPHER_LAT + 1);
  localparam logic [1:0]        LAST_BEAT = 2'(BLOCK_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CIPHER_LAT);

  state_t              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                kv_q, kv_d, err_q, err_d;
  logic                mv_q, mv_d, ml_q, ml_d;
  logic [WORD_W-1:0]   md_q, md_d;
  byte_mat_t           res_q, res_d;
  logic                key_we, dat_we, s_acc;

  // Loading states take beats unless abort is flushing this cycle.
  assign s_ready = !abort && (state_q == IDLE || state_q == LD_KEY || state_q == LD_DATA);
  assign s_acc   = s_valid && s_ready;

  aes_word_packer u_key_pack (
    .clk_i(clk), .rst_ni(rst), .we_i(key_we), .idx_i(beat_q), .word_i(s_data), .mat_o(key_o)
  );
  aes_word_packer u_dat_pack (
    .clk_i(clk), .rst_ni(rst), .we_i(dat_we), .idx_i(beat_q), .word_i(s_data), .mat_o(data_o)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Counters, key flag, result buffer and registered output beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q <= '0; wait_q <= '0; kv_q <= 1'b0; err_q <= 1'b0;
      mv_q <= 1'b0; ml_q <= 1'b0; md_q <= '0; res_q <= '0;
    end else begin
      beat_q <= beat_d; wait_q <= wait_d; kv_q <= kv_d; err_q <= err_d;
      mv_q <= mv_d; ml_q <= ml_d; md_q <= md_d; res_q <= res_d;
    end
  end

  // Next-state logic. The beat index is shared: it addresses the column being
  // loaded, then the column being sent, and wraps to 0 after the 4th beat.
  always_comb begin
    state_d = state_q; beat_d = beat_q; wait_d = wait_q; kv_d = kv_q; err_d = 1'b0;
    mv_d = mv_q; ml_d = ml_q; md_d = md_q; res_d = res_q;
    key_we = 1'b0; dat_we = 1'b0;
    if (abort) begin
      state_d = IDLE; beat_d = '0; wait_d = '0; mv_d = 1'b0; ml_d = 1'b0;
      if (state_q == LD_KEY) kv_d = 1'b0;  // half-written key is not usable
    end else begin
      unique case (state_q)
        IDLE: if (s_acc) begin
          if (s_key) begin
            key_we = 1'b1; beat_d = 2'd1; state_d = LD_KEY;
          end else if (kv_q) begin
            dat_we = 1'b1; beat_d = 2'd1; state_d = LD_DATA;
          end else begin
            err_d = 1'b1;  // plaintext with no key: drop the beat
          end
        end
        LD_KEY: if (s_acc) begin
          key_we = 1'b1; beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin kv_d = 1'b1; state_d = LD_DATA; end
        end
        LD_DATA: if (s_acc) begin
          dat_we = 1'b1; beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin state_d = CAPT; wait_d = WAIT_LOAD; end
        end
        CAPT: begin
          if (wait_q == '0) begin res_d = cipher_i; state_d = SEND; end
          else                wait_d = wait_q - WAIT_W'(1);
        end
        SEND: begin
          if (!mv_q) begin
            mv_d = 1'b1; md_d = col_to_word(res_q[beat_q]); ml_d = (beat_q == LAST_BEAT);
          end else if (m_ready) begin
            if (beat_q == LAST_BEAT) begin
              state_d = IDLE; mv_d = 1'b0; ml_d = 1'b0; beat_d = '0;
            end else begin
              beat_d = beat_q + 2'd1;
              md_d   = col_to_word(res_q[beat_q + 2'd1]);
              ml_d   = (beat_q + 2'd1 == LAST_BEAT);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign m_valid   = mv_q;
  assign m_data    = md_q;
  assign m_last    = ml_q;
  assign key_valid = kv_q;
  assign err       = err_q;
endmodule

// File: tb/tb_aes_block_stream.sv
// Bench for aes_block_stream: two builds (CIPHER_LAT 0 and 3) share stimulus,
// the idle one is held in reset. The cipher and the expected ciphertext come
// from a byte-level AES-128 model.
module tb_aes_block_stream;
  import aes_stream_pkg::*;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3, abort, s_valid, s_key, m_ready, sel;
  logic [31:0] s_data;
  logic s_ready0, m_valid0, m_last0, kv0, err0;
  logic s_ready3, m_valid3, m_last3, kv3, err3;
  logic [31:0] m_data0, m_data3;
  byte_mat_t key0, dat0, ciph0, key3, dat3, ciph3_now;
  byte_mat_t c3_d1 = '0, c3_d2 = '0, c3_d3 = '0;

  logic obs_s_ready, obs_m_valid, obs_m_last, obs_kv, obs_err;
  logic [31:0] obs_m_data;
  byte_mat_t obs_key, obs_dat;

  int n_cmp = 0, n_bad = 0;
  logic [127:0] mk, pt;

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01; p = x;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gm(r, p);
      p = gm(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic byte_mat_t aes_enc(input byte_mat_t k, input byte_mat_t p);
    logic [7:0] s[16], w[16], t[16];
    logic [7:0] a0, a1, a2, a3, rc;
    byte_mat_t r;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin w[i] = k[i/4][i%4]; s[i] = p[i/4][i%4] ^ w[i]; end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      t[0] = sb(w[13]); t[1] = sb(w[14]); t[2] = sb(w[15]); t[3] = sb(w[12]);
      w[0] = w[0] ^ t[0] ^ rc; w[1] = w[1] ^ t[1]; w[2] = w[2] ^ t[2]; w[3] = w[3] ^ t[3];
      for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
          s[4*c+3] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    end
    for (int i = 0; i < 16; i++) r[i/4][i%4] = s[i];
    return r;
  endfunction

  // Stream order: byte i of a 128-bit block is byte 0 of the first word at i=0.
  function automatic byte_mat_t to_mat(input logic [127:0] v);
    byte_mat_t m;
    for (int i = 0; i < 16; i++) m[i/4][i%4] = v[127-8*i -: 8];
    return m;
  endfunction

  function automatic logic [127:0] from_mat(input byte_mat_t m);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = m[i/4][i%4];
    return v;
  endfunction

  function automatic logic [127:0] exp_ct(input logic [127:0] k, input logic [127:0] p);
    return from_mat(aes_enc(to_mat(k), to_mat(p)));
  endfunction

  // ---------------- DUTs and cipher models ----------------
  assign ciph0 = aes_enc(key0, dat0);
  always_comb ciph3_now = aes_enc(key3, dat3);
  // Slow cipher: result only settles CIPHER_LAT edges after its inputs change.
  always @(posedge clk) begin
    c3_d1 <= ciph3_now; c3_d2 <= c3_d1; c3_d3 <= c3_d2;
  end

  aes_block_stream #(.CIPHER_LAT(0)) dut0 (
    .clk(clk), .rst(rst0), .abort(abort), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .s_key(s_key), .key_o(key0), .data_o(dat0), .cipher_i(ciph0),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0),
    .key_valid(kv0), .err(err0)
  );

  aes_block_stream #(.CIPHER_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .abort(abort), .s_valid(s_valid), .s_ready(s_ready3),
    .s_data(s_data), .s_key(s_key), .key_o(key3), .data_o(dat3), .cipher_i(c3_d3),
    .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3), .m_last(m_last3),
    .key_valid(kv3), .err(err3)
  );

  assign obs_s_ready = sel ? s_ready3 : s_ready0;
  assign obs_m_valid = sel ? m_valid3 : m_valid0;
  assign obs_m_last  = sel ? m_last3  : m_last0;
  assign obs_m_data  = sel ? m_data3  : m_data0;
  assign obs_kv      = sel ? kv3      : kv0;
  assign obs_err     = sel ? err3     : err0;
  assign obs_key     = sel ? key3     : key0;
  assign obs_dat     = sel ? dat3     : dat0;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " key_o"},     obs_key,     '0);
    chk({tag, " data_o"},    obs_dat,     '0);
    chk({tag, " m_data"},    obs_m_data,  '0);
    chk({tag, " m_valid"},   obs_m_valid, '0);
    chk({tag, " m_last"},    obs_m_last,  '0);
    chk({tag, " key_valid"}, obs_kv,      '0);
    chk({tag, " err"},       obs_err,     '0);
  endtask

  task automatic idle();
    @(negedge clk); s_valid = 1'b0; s_key = 1'b0; abort = 1'b0; #1;
  endtask

  // Offer one beat after 'gap' empty cycles; returns just after the accepting edge.
  task automatic send_beat(input logic [31:0] w, input logic k, input int gap, input string tag);
    int n;
    logic acc;
    repeat (gap) begin
      @(negedge clk); s_valid = 1'b0; s_data = $urandom; s_key = 1'($urandom_range(0, 1));
    end
    @(negedge clk); s_valid = 1'b1; s_data = w; s_key = k;
    n = 0; acc = 1'b0;
    while (!acc && n < 40) begin
      #1; acc = obs_s_ready;
      @(posedge clk); n++;
      if (!acc) @(negedge clk);
    end
    chk({tag, " accepted"}, acc, 1);
  endtask

  task automatic send_block(input logic [127:0] v, input logic is_key, input int max_gap,
                            input string tag);
    logic k;
    for (int w = 0; w < 4; w++) begin
      k = (w == 0) ? is_key : (is_key ? 1'($urandom_range(0, 1)) : 1'b0);
      send_beat(v[127-32*w -: 32], k, $urandom_range(0, max_gap), tag);
    end
  endtask

  // Called right after the 4th plaintext beat is accepted.
  task automatic recv_block(input logic [127:0] e, input int lat_exp, input int stall_k,
                            input int stall_n, input string tag);
    int lat;
    @(negedge clk); s_valid = 1'b0; s_key = 1'b0; m_ready = 1'b1; #1;
    chk({tag, " s_ready busy"}, obs_s_ready, 0);
    lat = 0;
    while (!obs_m_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk({tag, " latency"}, lat, lat_exp);
    for (int k = 0; k < 4; k++) begin
      chk({tag, " m_valid"}, obs_m_valid, 1);
      chk({tag, " m_data"},  obs_m_data,  e[127-32*k -: 32]);
      chk({tag, " m_last"},  obs_m_last,  (k == 3));
      if (k == stall_k)
        repeat (stall_n) begin
          m_ready = 1'b0; @(posedge clk); @(negedge clk);
          chk({tag, " stall m_data"},  obs_m_data,  e[127-32*k -: 32]);
          chk({tag, " stall m_valid"}, obs_m_valid, 1);
        end
      m_ready = 1'b1; @(posedge clk); @(negedge clk);
    end
    chk({tag, " m_valid drop"}, obs_m_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed/random sequence ----------------
  initial begin
    sel = 1'b0; rst0 = 1'b0; rst3 = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_key = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst0 = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 vector, then the same plaintext again with the stored key.
    send_block(FIPS_KEY, 1'b1, 0, "t1 key");
    idle();
    chk("t1 key_valid", obs_kv, 1);
    chk("t1 key_o", obs_key, to_mat(FIPS_KEY));
    send_block(FIPS_PT, 1'b0, 0, "t1 pt");
    recv_block(FIPS_CT, 2, -1, 0, "t1");
    chk("t1 data_o", obs_dat, to_mat(FIPS_PT));
    send_block(FIPS_PT, 1'b0, 0, "t2 pt");
    recv_block(FIPS_CT, 2, -1, 0, "t2");
    chk("t2 key_valid", obs_kv, 1);

    // Random key and plaintexts with input gaps and output back-pressure.
    mk = {$urandom, $urandom, $urandom, $urandom};
    send_block(mk, 1'b1, 3, "t4 key");
    for (int b = 0; b < 4; b++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_block(pt, 1'b0, 3, "t4 pt");
      recv_block(exp_ct(mk, pt), 2, (b == 0) ? 1 : b, (b == 0) ? 5 : $urandom_range(0, 3), "t4");
    end

    // Abort part-way through a data block: key survives, beat with abort is refused.
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_beat(pt[127:96], 1'b0, 0, "t5 pt");
    send_beat(pt[95:64],  1'b0, 0, "t5 pt");
    @(negedge clk); abort = 1'b1; s_valid = 1'b1; s_data = $urandom; #1;
    chk("t5 s_ready under abort", obs_s_ready, 0);
    idle();
    chk("t5 key_valid", obs_kv, 1);
    chk("t5 m_valid", obs_m_valid, 0);
    chk("t5 idle s_ready", obs_s_ready, 1);
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_block(pt, 1'b0, 2, "t5 pt2");
    recv_block(exp_ct(mk, pt), 2, 2, 2, "t5");

    // Abort during key load drops key_valid; a data beat then raises err.
    send_beat($urandom, 1'b1, 0, "t5k key");
    send_beat($urandom, 1'b0, 0, "t5k key");
    @(negedge clk); abort = 1'b1; s_valid = 1'b0;
    idle();
    chk("t5k key_valid", obs_kv, 0);
    send_beat($urandom, 1'b0, 0, "t5k data");
    idle();
    chk("t5k err", obs_err, 1);
    mk = {$urandom, $urandom, $urandom, $urandom};
    send_block(mk, 1'b1, 1, "t5k key2");
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_block(pt, 1'b0, 1, "t5k pt");
    recv_block(exp_ct(mk, pt), 2, 0, 1, "t5k");

    // Reset clears the key; an unkeyed data beat is taken but only pulses err.
    @(negedge clk); rst0 = 1'b0;
    @(negedge clk); rst0 = 1'b1;
    send_beat($urandom, 1'b0, 0, "t3 data");
    idle();
    chk("t3 err pulse", obs_err, 1);
    chk("t3 m_valid", obs_m_valid, 0);
    chk("t3 key_valid", obs_kv, 0);
    chk("t3 s_ready", obs_s_ready, 1);
    idle();
    chk("t3 err clear", obs_err, 0);
    chk("t3 idle s_ready", obs_s_ready, 1);
    chk("t3 m_valid later", obs_m_valid, 0);

    // CIPHER_LAT=3 build: reset during CAPT, then rerun the FIPS vector.
    @(negedge clk); sel = 1'b1; rst0 = 1'b0; rst3 = 1'b1;
    send_block(FIPS_KEY, 1'b1, 0, "t6 key");
    send_block(FIPS_PT, 1'b0, 0, "t6 pt");
    idle();
    @(negedge clk); rst3 = 1'b0; #1;
    chk_zero("t6 async reset");
    @(negedge clk); rst3 = 1'b1;
    send_block(FIPS_KEY, 1'b1, 0, "t6 key2");
    send_block(FIPS_PT, 1'b0, 0, "t6 pt2");
    recv_block(FIPS_CT, 5, 3, 2, "t6");
    mk = {$urandom, $urandom, $urandom, $urandom};
    send_block(mk, 1'b1, 2, "t6 key3");
    pt = {$urandom, $urandom, $urandom, $urandom};
    send_block(pt, 1'b0, 2, "t6 pt3");
    recv_block(exp_ct(mk, pt), 5, 1, 3, "t6r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
